// File: rtl/led_mode_ctrl.sv
// Push-button LED mode controller: 2-flop key synchronizer, debouncer with one-shot
// press detect, and an OFF/ON/SLOW/FAST mode FSM driving a blinking LED.
module led_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned SLOW_HALF    = 25_000_000,
    parameter int unsigned FAST_HALF    = 5_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key,
    output logic       led,
    output logic [1:0] mode,
    output logic       key_press
);

    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYC);
    localparam int unsigned BLINK_W = $clog2(SLOW_HALF);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    logic [1:0]         sync_q,      sync_d;
    logic               stable_q,    stable_d;
    logic [DEB_W-1:0]   deb_cnt_q,   deb_cnt_d;
    logic               key_press_q, key_press_d;
    mode_e              mode_q,      mode_d;
    logic               led_q,       led_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [BLINK_W-1:0] half_m1;

    // Synchronizer and debouncer; counter saturates one short of DEBOUNCE_CYC
    always_comb begin
        sync_d      = {sync_q[0], key};
        stable_d    = stable_q;
        deb_cnt_d   = '0;
        key_press_d = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYC - 1)) begin
                stable_d    = sync_q[1];
                key_press_d = ~sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Mode FSM and LED blinker; a press on the same edge as a toggle wins
    always_comb begin
        mode_d      = mode_q;
        led_d       = led_q;
        blink_cnt_d = '0;
        half_m1     = (mode_q == MODE_FAST) ? BLINK_W'(FAST_HALF - 1)
                                            : BLINK_W'(SLOW_HALF - 1);
        if (key_press_d) begin
            case (mode_q)
                MODE_OFF:  begin mode_d = MODE_ON;   led_d = 1'b1; end
                MODE_ON:   begin mode_d = MODE_SLOW; led_d = 1'b1; end
                MODE_SLOW: begin mode_d = MODE_FAST; led_d = 1'b1; end
                default:   begin mode_d = MODE_OFF;  led_d = 1'b0; end
            endcase
        end else begin
            case (mode_q)
                MODE_OFF: led_d = 1'b0;
                MODE_ON:  led_d = 1'b1;
                default: begin
                    if (blink_cnt_q == half_m1) begin
                        led_d = ~led_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q      <= 2'b11;
            stable_q    <= 1'b1;
            deb_cnt_q   <= '0;
            key_press_q <= 1'b0;
            mode_q      <= MODE_OFF;
            led_q       <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            sync_q      <= sync_d;
            stable_q    <= stable_d;
            deb_cnt_q   <= deb_cnt_d;
            key_press_q <= key_press_d;
            mode_q      <= mode_d;
            led_q       <= led_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign led       = led_q;
    assign mode      = mode_q;
    assign key_press = key_press_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: directed scenarios plus random key traffic, checked every
// cycle against a behavioural model built from run lengths and elapsed-time arithmetic.
module tb_led_mode_ctrl;

    localparam int unsigned DEB    = 4;
    localparam int unsigned SLOW_H = 8;
    localparam int unsigned FAST_H = 3;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key     = 1'b1;
    logic       led;
    logic [1:0] mode;
    logic       key_press;

    int total = 0;
    int bad   = 0;

    // model state: sync pipeline, accepted level, run of differing samples, mode, time in blink mode
    int m_s1, m_s2, m_stable, m_run, m_mode, m_press, m_led, m_t;

    led_mode_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .SLOW_HALF   (SLOW_H),
        .FAST_HALF   (FAST_H)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key      (key),
        .led      (led),
        .mode     (mode),
        .key_press(key_press)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input logic k, input logic r);
        int old_s2;
        int half;
        key     = k;
        sys_rst = r;
        @(posedge sys_clk);
        if (r) begin
            m_s1 = 1; m_s2 = 1; m_stable = 1; m_run = 0;
            m_mode = 0; m_press = 0; m_led = 0; m_t = 0;
        end else begin
            old_s2  = m_s2;
            m_press = 0;
            if (old_s2 != m_stable) begin
                m_run++;
                if (m_run == int'(DEB)) begin
                    m_stable = old_s2;
                    m_run    = 0;
                    m_press  = (old_s2 == 0) ? 1 : 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = int'(k);
            if (m_press != 0) begin
                m_mode = (m_mode + 1) % 4;
                m_t    = 0;
            end else if (m_mode >= 2) begin
                m_t++;
            end
            half  = (m_mode == 3) ? int'(FAST_H) : int'(SLOW_H);
            m_led = (m_mode == 0) ? 0 :
                    (m_mode == 1) ? 1 : (((m_t / half) % 2) == 0 ? 1 : 0);
        end
        #1;
        check("led",       32'(led),       32'(m_led));
        check("mode",      32'(mode),      32'(m_mode));
        check("key_press", 32'(key_press), 32'(m_press));
    endtask

    // hold key low until a press appears; n = edge count of the press, 0 if none within max
    task automatic wait_press(input int max, output int n);
        n = 0;
        for (int i = 1; i <= max; i++) begin
            tick(1'b0, 1'b0);
            if (key_press === 1'b1 && n == 0) n = i;
        end
    endtask

    task automatic press_release();
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    endtask

    initial begin
        int n;
        int run_len;
        logic kv;

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_led",  32'(led),  32'd0);
        check("rst_press", 32'(key_press), 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);

        // clean press, held long: pulse on 6th edge, only once
        wait_press(14, n);
        check("press_latency", 32'(n), 32'd6);
        check("press_mode_on", 32'(mode), 32'd1);
        check("press_led_on",  32'(led),  32'd1);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);

        // bounce: never long enough, then a real press
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        check("bounce_mode", 32'(mode), 32'd1);
        wait_press(6, n);
        check("bounce_press", 32'(n), 32'd6);
        check("slow_mode", 32'(mode), 32'd2);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b0);

        // collision: press lands on the SLOW terminal count
        for (int i = 0; i < 16 && (m_t % int'(SLOW_H)) != 2; i++) tick(1'b1, 1'b0);
        check("collide_phase", 32'(m_t % int'(SLOW_H)), 32'd2);
        wait_press(6, n);
        check("collide_press", 32'(n), 32'd6);
        check("collide_mode",  32'(mode), 32'd3);
        check("collide_led",   32'(led),  32'd1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("collide_led_hold", 32'(led), 32'd1);
        tick(1'b0, 1'b0);
        check("collide_toggle", 32'(led), 32'd0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);

        // wrap FAST -> OFF, LED stays dark
        press_release();
        check("wrap_mode", 32'(mode), 32'd0);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
        check("off_led", 32'(led), 32'd0);

        // reset mid-debounce while in FAST
        press_release();
        press_release();
        press_release();
        check("pre_rst_mode", 32'(mode), 32'd3);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("rst_mid_mode",  32'(mode), 32'd0);
        check("rst_mid_led",   32'(led),  32'd0);
        check("rst_mid_press", 32'(key_press), 32'd0);
        wait_press(10, n);
        check("post_rst_latency", 32'(n), 32'd6);
        check("post_rst_mode", 32'(mode), 32'd1);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);

        // random key traffic with occasional reset
        for (int r = 0; r < 500; r++) begin
            kv      = logic'($urandom_range(0, 1));
            run_len = int'($urandom_range(1, 9));
            for (int i = 0; i < run_len; i++) tick(kv, ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
